iotdf_stream_tx: RTL
====================

# iotdf_stream_tx

Transmit-side feeder for the IoT data filter. Accepts 128-bit IoT words from an upstream valid/ready source, serializes each word into 16 bytes (MSB byte first), and drives the filter's `in_en` / `iot_in` / `fn_sel` byte interface. It honours the filter's `busy` back-pressure and signals completion after a configured number of words. It sits between the data memory/DMA and the filter core.

## Interface
- `WCNT_W`, default 8: width of the word-count configuration.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `start`  in  1  one-cycle pulse that begins a stream; honoured only in IDLE.
- `cfg_fn`  in  3  function code; latched on an accepted `start`.
- `cfg_words`  in  WCNT_W  number of words to send; latched on an accepted `start`.
- `word_valid`  in  1  upstream word available.
- `word_data`  in  128  upstream word; byte [127:120] is sent first.
- `word_ready`  out  1  block accepts a word this cycle (transfer = valid & ready).
- `busy`  in  1  downstream back-pressure.
- `in_en`  out  1  `iot_in` holds a valid byte this cycle (registered).
- `iot_in`  out  8  data byte (registered).
- `fn_sel`  out  3  function code; held constant for the whole stream.
- `active`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the last byte of the last word.

## Operation
- FSM states: IDLE, SEND, DONE.
  - IDLE -> SEND on `start`, or IDLE -> DONE on `start` when `cfg_words`=0.
  - SEND -> DONE after byte 15 of word number `cfg_words` is emitted.
  - DONE -> IDLE unconditionally after one cycle. `done`=1 in DONE only.
- Buffering: a 128-bit shift register (current word) plus one 128-bit holding register.
  - `word_ready` = (state==SEND) & (holding empty) & (accepted words < `cfg_words`).
  - Words are never accepted in IDLE or DONE.
- Emission: each cycle in SEND with the shifter loaded and `busy`=0:
  - register `iot_in` ← shifter[127:120] and `in_en` ← 1;
  - shift the shifter left by 8; increment the 4-bit byte counter.
- After byte 15 the shifter reloads from holding in the same cycle, so there is no bubble between back-to-back words. If holding is empty, `in_en` drops until a word arrives (underrun gap; bytes are never reordered or skipped).
- `busy`=1 in cycle t:
  - `in_en`=0 in t+1; shifter, byte counter and word counter freeze.
  - Upstream acceptance into holding continues if holding is empty.
- Counters: `sent_words` and `acc_words` are WCNT_W wide; no wrap, because `cfg_words` ≤ 2^WCNT_W−1.
- `start` outside IDLE is ignored; `cfg_*` changes outside IDLE have no effect.
- `fn_sel` ← `cfg_fn` in the cycle after an accepted `start`. It holds that value through IDLE until the next accepted `start`.
- `iot_in` holds its last value when `in_en`=0.

## Timing
- Reset values: `in_en`=0, `iot_in`=0, `fn_sel`=0, `word_ready`=0, `active`=0, `done`=0; FSM IDLE; buffers empty.
- Reset mid-stream: the next cycle shows all reset values; the partial word is discarded with no `done`.
- Latency: word accepted at edge t into an empty shifter → byte 0 has `in_en`=1 in cycle t+1. A word of 16 bytes with no busy occupies 16 consecutive `in_en` cycles.
- The last byte's `in_en` is in cycle t; `done`=1 in t+1; `active`=0 and IDLE in t+2.
- Simultaneous shifter reload and holding refill in the same cycle is legal: the holding register is read then written.

## Structure
- Shared package (the one that holds the filter's function codes): FN_MAX=1 … FN_PMIN=7, BYTES_PER_WORD=16, WORD_W=128.
- Sub-module `iot_word_ser`: shifter, holding register and byte counter, with a load/shift/busy interface. The top level holds the FSM, word counters and configuration latches.

## Test plan
- Single word 0x00112233_44556677_8899AABB_CCDDEEFF, `cfg_words`=1, `cfg_fn`=3 → `fn_sel`=3; bytes 00,11,…,FF on 16 consecutive `in_en` cycles; `done` one cycle after FF.
- `cfg_words`=8, `word_valid` always high, `busy`=0 → 128 consecutive `in_en` cycles; exactly 8 `word_ready` handshakes; one `done`.
- `busy` high for 3 cycles after byte 5 → `in_en` low for exactly 3 cycles; byte 6 follows; no byte lost or duplicated.
- Upstream withholds word 2 for 5 cycles → `in_en` gap after byte 15 of word 1; word 2 byte 0 appears 1 cycle after its handshake.
- `cfg_words`=0 → `done` the cycle after `start`; no `in_en`; `word_ready` never high. A second `start` during SEND is ignored.
- `rst`=0 during byte 9 → all outputs at reset values next cycle; a new `start` streams cleanly from byte 0.

Source files
------------

// File: rtl/iotdf_stream_tx_pkg.sv
// iotdf_stream_tx_pkg: filter function codes, word geometry and feeder FSM states
package iotdf_stream_tx_pkg;
    typedef enum logic [2:0] {
        FN_NONE    = 3'd0,
        FN_MAX     = 3'd1,
        FN_MIN     = 3'd2,
        FN_AVG     = 3'd3,
        FN_EXTRACT = 3'd4,
        FN_EXCLUDE = 3'd5,
        FN_PMAX    = 3'd6,
        FN_PMIN    = 3'd7
    } fn_e;
    localparam int BYTES_PER_WORD = 16;
    localparam int WORD_W = 128;
    localparam int BYTE_W = 8;
    localparam int BCNT_W = $clog2(BYTES_PER_WORD);
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [BYTE_W-1:0] byte_t;
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE} state_e;
    function automatic byte_t top_byte(input word_t w);
        return w[WORD_W-1 -: BYTE_W];
    endfunction
endpackage

// File: rtl/iotdf_stream_tx_word_ser.sv
// iot_word_ser: word shifter with one-deep holding register, emits one byte per free cycle
module iot_word_ser
    import iotdf_stream_tx_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  en_i,
    input  logic  busy_i,
    input  logic  load_i,
    input  word_t load_data_i,
    output logic  hold_full_o,
    output logic  last_o,
    output logic  in_en_o,
    output byte_t byte_o
);
    word_t             sh_q, sh_d, hold_q, hold_d, src;
    logic              sh_vld_q, sh_vld_d, hold_vld_q, hold_vld_d;
    logic              in_en_q, in_en_d, go, avail, take;
    logic [BCNT_W-1:0] cnt_q, cnt_d;
    byte_t             byte_q, byte_d;

    assign hold_full_o = hold_vld_q;
    assign in_en_o     = in_en_q;
    assign byte_o      = byte_q;

    // Next word comes from holding if full, else straight from the upstream transfer
    always_comb begin
        go         = en_i & ~busy_i;
        avail      = hold_vld_q | load_i;
        src        = hold_vld_q ? hold_q : load_data_i;
        last_o     = go & sh_vld_q & (cnt_q == BCNT_W'(BYTES_PER_WORD - 1));
        take       = go & avail & (~sh_vld_q | last_o);
        sh_d       = sh_q;
        sh_vld_d   = sh_vld_q;
        cnt_d      = cnt_q;
        in_en_d    = 1'b0;
        byte_d     = byte_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q & ~take;
        if (go && sh_vld_q) begin
            in_en_d  = 1'b1;
            byte_d   = top_byte(sh_q);
            sh_d     = last_o ? src : sh_q << BYTE_W;
            sh_vld_d = ~last_o | avail;
            cnt_d    = cnt_q + BCNT_W'(1);
        end else if (take) begin
            in_en_d  = 1'b1;
            byte_d   = top_byte(src);
            sh_d     = src << BYTE_W;
            sh_vld_d = 1'b1;
            cnt_d    = BCNT_W'(1);
        end
        if (load_i && !(take && !hold_vld_q)) begin
            hold_d     = load_data_i;
            hold_vld_d = 1'b1;
        end
    end

    // Buffer and output byte registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sh_q       <= '0;
            hold_q     <= '0;
            sh_vld_q   <= 1'b0;
            hold_vld_q <= 1'b0;
            cnt_q      <= '0;
            in_en_q    <= 1'b0;
            byte_q     <= '0;
        end else begin
            sh_q       <= sh_d;
            hold_q     <= hold_d;
            sh_vld_q   <= sh_vld_d;
            hold_vld_q <= hold_vld_d;
            cnt_q      <= cnt_d;
            in_en_q    <= in_en_d;
            byte_q     <= byte_d;
        end
    end
endmodule

// File: rtl/iotdf_stream_tx.sv
// iotdf_stream_tx: streams a configured number of 128-bit words to the filter byte interface
module iotdf_stream_tx
    import iotdf_stream_tx_pkg::*;
#(
    parameter int WCNT_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [2:0]        cfg_fn_i,
    input  logic [WCNT_W-1:0] cfg_words_i,
    input  logic              word_valid_i,
    input  logic [127:0]      word_data_i,
    output logic              word_ready_o,
    input  logic              busy_i,
    output logic              in_en_o,
    output logic [7:0]        iot_in_o,
    output logic [2:0]        fn_sel_o,
    output logic              active_o,
    output logic              done_o
);
    state_e            state_q;
    logic [WCNT_W-1:0] words_q, acc_q, sent_q;
    logic [2:0]        fn_q;
    logic              active_q, done_q, hold_full, ser_last, xfer;

    assign word_ready_o = (state_q == ST_SEND) && !hold_full && (acc_q < words_q);
    assign xfer         = word_valid_i & word_ready_o;
    assign fn_sel_o     = fn_q;
    assign active_o     = active_q;
    assign done_o       = done_q;

    iot_word_ser u_ser (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (state_q == ST_SEND),
        .busy_i      (busy_i),
        .load_i      (xfer),
        .load_data_i (word_data_i),
        .hold_full_o (hold_full),
        .last_o      (ser_last),
        .in_en_o     (in_en_o),
        .byte_o      (iot_in_o)
    );

    // Stream FSM; DONE is entered the cycle after the last byte is on the bus
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            words_q  <= '0;
            acc_q    <= '0;
            sent_q   <= '0;
            fn_q     <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            acc_q  <= acc_q + WCNT_W'(xfer);
            sent_q <= sent_q + WCNT_W'(ser_last);
            case (state_q)
                ST_IDLE: if (start_i) begin
                    words_q  <= cfg_words_i;
                    fn_q     <= cfg_fn_i;
                    acc_q    <= '0;
                    sent_q   <= '0;
                    active_q <= 1'b1;
                    state_q  <= (cfg_words_i == '0) ? ST_DONE : ST_SEND;
                    done_q   <= (cfg_words_i == '0);
                end
                ST_SEND: if (sent_q == words_q) begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    active_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
